// File: rtl/bayer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bayer_pkg
// Description : Shared types and helpers for the Bayer demosaic block:
//               CFA pattern enum, colour enum, colour lookup and address
//               width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bayer_pkg;

    localparam int PIXEL_W = 8;
    localparam int RGB_W   = 3 * PIXEL_W;

    // Colour of pixel (0,0) and its row pair
    typedef enum logic [1:0] {
        RGGB = 2'd0,
        GRBG = 2'd1,
        GBRG = 2'd2,
        BGGR = 2'd3
    } bayer_t;

    typedef enum logic [1:0] {
        RED   = 2'd0,
        GREEN = 2'd1,
        BLUE  = 2'd2
    } colour_t;

    // Address width for a memory or counter of n entries; never below 1 bit
    function automatic int unsigned addr_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Colour filter at a site, indexed by row parity y0 and column parity x0
    function automatic colour_t colour_of(input bayer_t pat, input logic y0, input logic x0);
        colour_t c;
        c = GREEN;
        case (pat)
            RGGB: c = (!y0 && !x0) ? RED  : ((y0 && x0) ? BLUE : GREEN);
            GRBG: c = (!y0 &&  x0) ? RED  : ((y0 && !x0) ? BLUE : GREEN);
            GBRG: c = ( y0 && !x0) ? RED  : ((!y0 && x0) ? BLUE : GREEN);
            BGGR: c = ( y0 &&  x0) ? RED  : ((!y0 && !x0) ? BLUE : GREEN);
            default: c = GREEN;
        endcase
        return c;
    endfunction

endpackage : bayer_pkg
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer
// Description : One-line pixel store. Registered read with one cycle of
//               latency and an independent write port; maps onto block RAM.
//               Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module line_buffer
    import bayer_pkg::*;
#(
    parameter int DEPTH      = 640,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = addr_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Write port: store the pixel leaving the first pipeline stage
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read port: registered output, returns the previous line's sample
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : line_buffer
`default_nettype wire

// File: rtl/bayer_demosaic.sv
`default_nettype none
// ============================================================================
// Module      : bayer_demosaic
// Description : RAW8 Bayer to RGB888 converter using a 2x2 window
//               (above-left, above, left, current). Two-cycle fixed latency,
//               full rate, gaps allowed. Row 0 and column 0 emit black.
// Revision    : 1.0 - initial release
// ============================================================================
module bayer_demosaic
    import bayer_pkg::*;
#(
    parameter int     WIDTH         = 640,
    parameter int     HEIGHT        = 480,
    parameter bayer_t BAYER_PATTERN = RGGB
) (
    input  logic                pixel_clk,
    input  logic                reset,
    input  logic                pixel_valid,
    input  logic [PIXEL_W-1:0]  pixel,
    input  logic                sof_in,
    output logic [RGB_W-1:0]    rgb,
    output logic                rgb_valid,
    output logic                rgb_sof,
    output logic                rgb_eol
);

    localparam int             XW     = addr_width(WIDTH);
    localparam int             YW     = addr_width(HEIGHT);
    localparam logic [XW-1:0]  X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0]  Y_LAST = YW'(HEIGHT - 1);

    // Raster counters: position the next valid pixel will take
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [XW-1:0] cur_x_d;
    logic [YW-1:0] cur_y_d;

    // S1 stage
    logic               s1_valid_q;
    logic [PIXEL_W-1:0] s1_pix_q;
    logic [XW-1:0]      s1_x_q;
    logic [YW-1:0]      s1_y_q;

    // Window neighbours carried from the previous S1 pixel
    logic [PIXEL_W-1:0] left_q;
    logic [PIXEL_W-1:0] above_left_q;
    logic [PIXEL_W-1:0] above_d;

    // Colour mux / averager
    logic [PIXEL_W-1:0] win_d [4];
    logic [PIXEL_W-1:0] r_d, b_d;
    logic [PIXEL_W:0]   g_sum_d;
    colour_t            col_d;
    logic [RGB_W-1:0]   rgb_d;

    // Output registers
    logic [RGB_W-1:0] rgb_q;
    logic             rgb_valid_q, rgb_sof_q, rgb_eol_q;

    // Position of the incoming pixel (sof realigns) and the counter advance
    always_comb begin
        cur_x_d = (pixel_valid && sof_in) ? '0 : x_q;
        cur_y_d = (pixel_valid && sof_in) ? '0 : y_q;
        x_d     = x_q;
        y_d     = y_q;
        if (pixel_valid) begin
            if (cur_x_d == X_LAST) begin
                x_d = '0;
                y_d = (cur_y_d == Y_LAST) ? '0 : cur_y_d + 1'b1;
            end else begin
                x_d = cur_x_d + 1'b1;
                y_d = cur_y_d;
            end
        end
    end

    // Counter state and S0 -> S1 capture
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            x_q        <= '0;
            y_q        <= '0;
            s1_valid_q <= 1'b0;
            s1_pix_q   <= '0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            s1_valid_q <= pixel_valid;
            if (pixel_valid) begin
                s1_pix_q <= pixel;
                s1_x_q   <= cur_x_d;
                s1_y_q   <= cur_y_d;
            end
        end
    end

    // Read address x is issued in S0; write address is the S1 column, which
    // differs from the read column for any legal WIDTH.
    line_buffer #(
        .DEPTH      (WIDTH),
        .DATA_WIDTH (PIXEL_W),
        .ADDR_WIDTH (XW)
    ) u_line_buffer (
        .clk_i     (pixel_clk),
        .rd_en_i   (pixel_valid),
        .rd_addr_i (cur_x_d),
        .rd_data_o (above_d),
        .wr_en_i   (s1_valid_q),
        .wr_addr_i (s1_x_q),
        .wr_data_i (s1_pix_q)
    );

    // Shift the window only on S1-valid cycles so input gaps are transparent
    always_ff @(posedge pixel_clk) begin
        if (s1_valid_q) begin
            left_q       <= s1_pix_q;
            above_left_q <= above_d;
        end
    end

    // Route each window sample by its CFA colour; average the two greens
    always_comb begin
        win_d[0] = above_left_q;
        win_d[1] = above_d;
        win_d[2] = left_q;
        win_d[3] = s1_pix_q;
        r_d      = '0;
        b_d      = '0;
        g_sum_d  = '0;
        col_d    = GREEN;
        for (int i = 0; i < 4; i++) begin
            // entries 0,1 sit one row up; entries 0,2 sit one column left
            col_d = colour_of(BAYER_PATTERN, s1_y_q[0] ^ (i < 2), s1_x_q[0] ^ (i % 2 == 0));
            case (col_d)
                RED:     r_d = win_d[i];
                BLUE:    b_d = win_d[i];
                default: g_sum_d = g_sum_d + {1'b0, win_d[i]};
            endcase
        end
        if (s1_x_q == '0 || s1_y_q == '0) begin
            rgb_d = '0;
        end else begin
            rgb_d = {r_d, 8'(g_sum_d >> 1), b_d};
        end
    end

    // Output stage: rgb holds between valid pixels, tags only with valid
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            rgb_q       <= '0;
            rgb_valid_q <= 1'b0;
            rgb_sof_q   <= 1'b0;
            rgb_eol_q   <= 1'b0;
        end else begin
            rgb_valid_q <= s1_valid_q;
            rgb_sof_q   <= s1_valid_q && (s1_x_q == '0) && (s1_y_q == '0);
            rgb_eol_q   <= s1_valid_q && (s1_x_q == X_LAST);
            if (s1_valid_q) begin
                rgb_q <= rgb_d;
            end
        end
    end

    assign rgb       = rgb_q;
    assign rgb_valid = rgb_valid_q;
    assign rgb_sof   = rgb_sof_q;
    assign rgb_eol   = rgb_eol_q;

endmodule : bayer_demosaic
`default_nettype wire

// File: tb/tb_bayer_demosaic.sv
`default_nettype none
// ============================================================================
// Module      : tb_bayer_demosaic
// Description : Directed scoreboard bench for bayer_demosaic, WIDTH=HEIGHT=4,
//               RGGB. A coordinate-based reference model predicts each
//               output when its pixel is driven.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bayer_demosaic;
    import bayer_pkg::*;

    localparam int W = 4;
    localparam int H = 4;

    logic        pixel_clk = 1'b0;
    logic        reset;
    logic        pixel_valid;
    logic [7:0]  pixel;
    logic        sof_in;
    logic [23:0] rgb;
    logic        rgb_valid, rgb_sof, rgb_eol;

    bayer_demosaic #(.WIDTH(W), .HEIGHT(H), .BAYER_PATTERN(RGGB)) dut (
        .pixel_clk   (pixel_clk),
        .reset       (reset),
        .pixel_valid (pixel_valid),
        .pixel       (pixel),
        .sof_in      (sof_in),
        .rgb         (rgb),
        .rgb_valid   (rgb_valid),
        .rgb_sof     (rgb_sof),
        .rgb_eol     (rgb_eol)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        logic [23:0] rgb;
        logic        sof;
        logic        eol;
        int          stamp;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    bit         mon_en = 0;
    int         bx = 0, by = 0;
    logic [7:0] img [H][W];

    always @(posedge pixel_clk) cyc <= cyc + 1;

    // Reference: gather the 2x2 window by absolute coordinates, RGGB sites
    function automatic logic [23:0] model(input int x, input int y);
        logic [7:0] r, b, v;
        int gsum;
        r = 0; b = 0; gsum = 0;
        if (x == 0 || y == 0) return 24'h0;
        for (int yy = y - 1; yy <= y; yy++) begin
            for (int xx = x - 1; xx <= x; xx++) begin
                v = img[yy][xx];
                if (yy % 2 == 0 && xx % 2 == 0)      r = v;
                else if (yy % 2 == 1 && xx % 2 == 1) b = v;
                else                                 gsum += v;
            end
        end
        return {r, 8'(gsum / 2), b};
    endfunction

    // Drive one pixel at a falling edge and predict its output
    task automatic send(input logic [7:0] p, input logic s);
        exp_t e;
        if (s) begin bx = 0; by = 0; end
        img[by][bx] = p;
        e.rgb   = model(bx, by);
        e.sof   = (bx == 0 && by == 0);
        e.eol   = (bx == W - 1);
        e.stamp = cyc;
        sb.push_back(e);
        pixel_valid = 1'b1;
        pixel       = p;
        sof_in      = s;
        @(negedge pixel_clk);
        pixel_valid = 1'b0;
        sof_in      = 1'b0;
        if (bx == W - 1) begin
            bx = 0;
            by = (by == H - 1) ? 0 : by + 1;
        end else begin
            bx = bx + 1;
        end
    endtask

    task automatic idle(input int n);
        pixel_valid = 1'b0;
        repeat (n) @(negedge pixel_clk);
    endtask

    // Send n pixels of an RGGB-style pattern from the current position
    task automatic frame(input logic [7:0] r, input logic [7:0] ge, input logic [7:0] go,
                         input logic [7:0] b, input bit gaps, input int n, input bit first_sof);
        logic [7:0] p;
        for (int i = 0; i < n; i++) begin
            if (i == 0 && first_sof) begin bx = 0; by = 0; end
            if (by % 2 == 0) p = (bx % 2 == 0) ? r : ge;
            else             p = (bx % 2 == 0) ? go : b;
            send(p, i == 0 && first_sof);
            if (gaps) idle($urandom_range(0, 2));
        end
    endtask

    // Output monitor: compare every valid output against the scoreboard
    always @(negedge pixel_clk) begin
        if (mon_en) begin
            if (rgb_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_output: observed rgb=%h, required no output", rgb);
                end else begin
                    mon_e = sb.pop_front();
                    checks += 4;
                    assert (rgb === mon_e.rgb) else begin
                        errors++;
                        $error("FAIL rgb: observed %h expected %h", rgb, mon_e.rgb);
                    end
                    assert (rgb_sof === mon_e.sof) else begin
                        errors++;
                        $error("FAIL rgb_sof: observed %b expected %b", rgb_sof, mon_e.sof);
                    end
                    assert (rgb_eol === mon_e.eol) else begin
                        errors++;
                        $error("FAIL rgb_eol: observed %b expected %b", rgb_eol, mon_e.eol);
                    end
                    assert (cyc === mon_e.stamp + 2) else begin
                        errors++;
                        $error("FAIL latency: observed cycle %0d expected %0d", cyc, mon_e.stamp + 2);
                    end
                end
            end else begin
                checks++;
                assert (rgb_sof === 1'b0 && rgb_eol === 1'b0) else begin
                    errors++;
                    $error("FAIL tags_idle: observed sof=%b eol=%b expected 0 0", rgb_sof, rgb_eol);
                end
            end
        end
    end

    initial begin
        reset       = 1'b1;
        pixel_valid = 1'b0;
        pixel       = 8'h00;
        sof_in      = 1'b0;
        repeat (3) @(negedge pixel_clk);
        reset = 1'b0;

        // Reset state
        checks += 4;
        assert (rgb === 24'h0) else begin
            errors++; $error("FAIL reset_rgb: observed %h expected 000000", rgb);
        end
        assert (rgb_valid === 1'b0) else begin
            errors++; $error("FAIL reset_valid: observed %b expected 0", rgb_valid);
        end
        assert (rgb_sof === 1'b0) else begin
            errors++; $error("FAIL reset_sof: observed %b expected 0", rgb_sof);
        end
        assert (rgb_eol === 1'b0) else begin
            errors++; $error("FAIL reset_eol: observed %b expected 0", rgb_eol);
        end
        mon_en = 1;

        // Uniform 0x80 frame, continuous
        frame(8'h80, 8'h80, 8'h80, 8'h80, 0, W * H, 1);
        // RGGB frame, two back-to-back, counters wrapping on their own
        frame(8'h10, 8'h20, 8'h40, 8'h30, 0, W * H, 0);
        frame(8'h10, 8'h20, 8'h40, 8'h30, 0, W * H, 0);
        // Same frame with random gaps
        frame(8'h10, 8'h20, 8'h40, 8'h30, 1, W * H, 0);
        idle(3);

        // Reset mid-row 2: the pixel driven just before reset never emerges
        frame(8'h10, 8'h20, 8'h40, 8'h30, 0, 2 * W + 2, 0);
        void'(sb.pop_back());
        reset = 1'b1;
        @(negedge pixel_clk);
        reset = 1'b0;
        bx = 0;
        by = 0;
        checks++;
        assert (rgb_valid === 1'b0) else begin
            errors++; $error("FAIL rst_gap1: observed %b expected 0", rgb_valid);
        end
        send(8'h10, 1'b0);
        checks++;
        assert (rgb_valid === 1'b0) else begin
            errors++; $error("FAIL rst_gap2: observed %b expected 0", rgb_valid);
        end
        frame(8'h10, 8'h20, 8'h40, 8'h30, 0, W * H - 1, 0);

        // sof_in at counter (2,1), then a 0xFF/0xFE green frame
        frame(8'h55, 8'h66, 8'h77, 8'h88, 0, W + 2, 0);
        frame(8'h11, 8'hFF, 8'hFE, 8'h22, 0, W * H, 1);

        // Drain the pipeline with a bound
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(negedge pixel_clk);
        end
        idle(2);
        checks++;
        assert (sb.size() == 0) else begin
            errors++; $error("FAIL drain: observed %0d pending outputs expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_bayer_demosaic
`default_nettype wire
